// File: rtl/sev_seg_displays_scanner.sv
`default_nettype none
// ============================================================================
// Module   : sev_seg_displays_scanner
// Brief    : Time-multiplexing scanner for a 4-digit seven-segment display.
//            One digit is driven per slot. Each slot begins with a blanking
//            interval that suppresses ghosting. All pin outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module sev_seg_displays_scanner #(
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] digit_0,
  input  logic [6:0] digit_1,
  input  logic [6:0] digit_2,
  input  logic [6:0] digit_3,
  input  logic [3:0] dots,
  output logic [6:0] segments_out,
  output logic       dot_out,
  output logic [3:0] digit_sel,
  output logic       scan_tick
);

  localparam int                 C_CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]         C_SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic               C_DOT_OFF  = SEG_ACTIVE_LOW;
  localparam logic [3:0]         C_SEL_OFF  = SEL_ACTIVE_LOW ? 4'hF : 4'h0;

  logic               running_q, running_d;
  logic [1:0]         idx_q, idx_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]         pat_q, pat_d;     // {dot, segments g..a}, 1 = lit
  logic               w_load;
  logic [7:0]         w_pat_src;
  logic               w_in_blank;
  logic               w_show;
  logic [6:0]         w_seg_lit;
  logic               w_dot_lit;
  logic [3:0]         w_sel_lit;
  logic               w_tick;

  // Slot sequencing: start from slot 0 on enable, advance slots while running.
  always_comb begin
    running_d = running_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    w_load    = 1'b0;
    if (!running_q) begin
      if (en) begin
        running_d = 1'b1;
        idx_d     = 2'd0;
        cnt_d     = '0;
        w_load    = 1'b1;
      end
    end else if (!en) begin
      running_d = 1'b0;
      idx_d     = 2'd0;
      cnt_d     = '0;
    end else if (cnt_q != C_CNT_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d  = '0;
      idx_d  = idx_q + 2'd1;
      w_load = 1'b1;
    end
  end

  // Select the pattern of the digit about to be shown; only captured on slot entry.
  always_comb begin
    case (idx_d)
      2'd0:    w_pat_src = {dots[0], digit_0};
      2'd1:    w_pat_src = {dots[1], digit_1};
      2'd2:    w_pat_src = {dots[2], digit_2};
      default: w_pat_src = {dots[3], digit_3};
    endcase
    pat_d = w_load ? w_pat_src : pat_q;
  end

  // Blanking window at the start of each slot; absent entirely when zero-length.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign w_in_blank = 1'b0;
  end else begin : g_blank
    localparam logic [C_CNT_W-1:0] C_BLANK = C_CNT_W'(BLANK_CYCLES);
    assign w_in_blank = (cnt_d < C_BLANK);
  end

  // Output values derived from next state so the registered pins match the state
  // registers in the same cycle.
  always_comb begin
    w_show    = running_d && !w_in_blank;
    w_sel_lit = w_show ? (4'b0001 << idx_d) : 4'b0000;
    w_seg_lit = w_show ? pat_d[6:0] : 7'h00;
    w_dot_lit = w_show ? pat_d[7] : 1'b0;
    w_tick    = running_d && (idx_d == 2'd3) && (cnt_d == C_CNT_LAST);
  end

  // State and pin registers; async reset forces the inactive pin levels at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running_q    <= 1'b0;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      pat_q        <= 8'h00;
      segments_out <= C_SEG_OFF;
      dot_out      <= C_DOT_OFF;
      digit_sel    <= C_SEL_OFF;
      scan_tick    <= 1'b0;
    end else begin
      running_q    <= running_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      pat_q        <= pat_d;
      segments_out <= w_seg_lit ^ {7{SEG_ACTIVE_LOW}};
      dot_out      <= w_dot_lit ^ SEG_ACTIVE_LOW;
      digit_sel    <= w_sel_lit ^ {4{SEL_ACTIVE_LOW}};
      scan_tick    <= w_tick;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sev_seg_displays_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_sev_seg_displays_scanner
// Brief    : Bench for sev_seg_displays_scanner. Two instances: A (8/2, active
//            low) and B (8/0, active high), checked against a position-based
//            reference model plus directed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sev_seg_displays_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_a, en_b;
  logic [6:0] dg_a [4];
  logic [6:0] dg_b [4];
  logic [3:0] dt_a, dt_b;
  logic [6:0] seg_a, seg_b;
  logic       dot_a, dot_b;
  logic [3:0] sel_a, sel_b;
  logic       tick_a, tick_b;

  int n_err = 0;
  int n_chk = 0;

  // reference model state: running flag, position within frame, shown pattern
  bit         ma_run, mb_run;
  int         ma_pos, mb_pos;
  logic [7:0] ma_pat, mb_pat;

  always #5 clk = ~clk;

  sev_seg_displays_scanner #(
    .REFRESH_DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .en(en_a),
    .digit_0(dg_a[0]), .digit_1(dg_a[1]), .digit_2(dg_a[2]), .digit_3(dg_a[3]),
    .dots(dt_a), .segments_out(seg_a), .dot_out(dot_a), .digit_sel(sel_a),
    .scan_tick(tick_a)
  );

  sev_seg_displays_scanner #(
    .REFRESH_DIV(8), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0)
  ) u_dut_b (
    .clk(clk), .rst(rst), .en(en_b),
    .digit_0(dg_b[0]), .digit_1(dg_b[1]), .digit_2(dg_b[2]), .digit_3(dg_b[3]),
    .dots(dt_b), .segments_out(seg_b), .dot_out(dot_b), .digit_sel(sel_b),
    .scan_tick(tick_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected pins from frame position: slot = pos/rd, in-slot count = pos%rd.
  function automatic logic [12:0] expect_out(input bit run, input int pos, input logic [7:0] pat,
                                             input int rd, input int bl, input bit sal, input bit sell);
    logic [6:0] seg;
    logic       d;
    logic [3:0] sel;
    logic       t;
    seg = 7'h00;
    d   = 1'b0;
    sel = 4'h0;
    t   = run && (pos == 4 * rd - 1);
    if (run && (pos % rd) >= bl) begin
      seg = pat[6:0];
      d   = pat[7];
      sel = 4'b0001 << (pos / rd);
    end
    if (sal) begin
      seg = ~seg;
      d   = ~d;
    end
    if (sell) sel = ~sel;
    return {seg, d, sel, t};
  endfunction

  task automatic model_step(inout bit run, inout int pos, inout logic [7:0] pat,
                            input logic en, input logic [27:0] dg, input logic [3:0] dt, input int rd);
    if (!run) begin
      if (en) begin
        run = 1'b1;
        pos = 0;
        pat = {dt[0], dg[6:0]};
      end
    end else if (!en) begin
      run = 1'b0;
      pos = 0;
    end else begin
      pos = (pos + 1) % (4 * rd);
      if (pos % rd == 0) pat = {dt[pos / rd], dg[(pos / rd) * 7 +: 7]};
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step(ma_run, ma_pos, ma_pat, en_a, {dg_a[3], dg_a[2], dg_a[1], dg_a[0]}, dt_a, 8);
    model_step(mb_run, mb_pos, mb_pat, en_b, {dg_b[3], dg_b[2], dg_b[1], dg_b[0]}, dt_b, 8);
    #1;
    chk("A_pins", {19'd0, seg_a, dot_a, sel_a, tick_a}, {19'd0, expect_out(ma_run, ma_pos, ma_pat, 8, 2, 1'b1, 1'b1)});
    chk("B_pins", {19'd0, seg_b, dot_b, sel_b, tick_b}, {19'd0, expect_out(mb_run, mb_pos, mb_pat, 8, 0, 1'b0, 1'b0)});
    chk("B_onehot", {31'd0, ($countones(sel_b) <= 1)}, 32'd1);
  endtask

  task automatic model_reset();
    ma_run = 1'b0; ma_pos = 0; ma_pat = 8'h00;
    mb_run = 1'b0; mb_pos = 0; mb_pat = 8'h00;
  endtask

  // Reset pulse between clock edges; pins must go inactive with no edge.
  task automatic async_reset();
    #1 rst = 1'b1;
    #1;
    chk("A_async_rst", {19'd0, seg_a, dot_a, sel_a, tick_a}, {19'd0, 7'h7F, 1'b1, 4'hF, 1'b0});
    chk("B_async_rst", {19'd0, seg_b, dot_b, sel_b, tick_b}, 32'd0);
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    en_a = 1'b0; en_b = 1'b0; dt_a = 4'h0; dt_b = 4'h0;
    for (int i = 0; i < 4; i++) begin
      dg_a[i] = 7'h00;
      dg_b[i] = 7'h00;
    end
    model_reset();

    // reset state before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("A_reset", {19'd0, seg_a, dot_a, sel_a, tick_a}, {19'd0, 7'h7F, 1'b1, 4'hF, 1'b0});
    chk("B_reset", {19'd0, seg_b, dot_b, sel_b, tick_b}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    step();

    // directed scan with the reference digit set
    dg_a[0] = 7'h3F; dg_a[1] = 7'h06; dg_a[2] = 7'h5B; dg_a[3] = 7'h4F; dt_a = 4'b0101;
    dg_b[0] = 7'h3F; dg_b[1] = 7'h06; dg_b[2] = 7'h5B; dg_b[3] = 7'h4F; dt_b = 4'b0000;
    en_a = 1'b1; en_b = 1'b1;
    for (int k = 0; k < 70; k++) begin
      step();
      if (k == 0)  chk("s0_blank_sel", {28'd0, sel_a}, 32'hF);
      if (k == 0)  chk("B_s0_cnt0", {21'd0, sel_b, seg_b}, {21'd0, 4'b0001, 7'h3F});
      if (k == 2)  chk("s0_pins", {20'd0, sel_a, seg_a, dot_a}, {20'd0, 4'b1110, 7'h40, 1'b0});
      if (k == 7)  chk("s0_hold_seg", {25'd0, seg_a}, {25'd0, 7'h40});
      if (k == 10) chk("s1_pins", {20'd0, sel_a, seg_a, dot_a}, {20'd0, 4'b1101, 7'h79, 1'b1});
      if (k == 18) chk("s2_pins", {20'd0, sel_a, seg_a, dot_a}, {20'd0, 4'b1011, 7'h24, 1'b0});
      if (k == 26) chk("s3_pins", {20'd0, sel_a, seg_a, dot_a}, {20'd0, 4'b0111, 7'h30, 1'b1});
      if (k == 30) chk("tick_early", {31'd0, tick_a}, 32'd0);
      if (k == 31) chk("tick_frame", {31'd0, tick_a}, 32'd1);
      if (k == 34) chk("s0_new_seg", {25'd0, seg_a}, {25'd0, 7'h00});
      if (k == 54) chk("en_drop", {19'd0, seg_a, dot_a, sel_a, tick_a}, {19'd0, 7'h7F, 1'b1, 4'hF, 1'b0});
      if (k == 58) chk("restart_blank", {28'd0, sel_a}, 32'hF);
      if (k == 59) chk("restart_sel", {28'd0, sel_a}, {28'd0, 4'b1110});
      if (k == 63) chk("no_tick_after_restart", {31'd0, tick_a}, 32'd0);
      if (k == 4)  dg_a[0] = 7'h7F;
      if (k == 53) en_a = 1'b0;
      if (k == 56) en_a = 1'b1;
    end

    // async reset mid-scan, then idle with en low
    en_a = 1'b0;
    async_reset();
    step();
    step();

    // randomized traffic
    en_a = 1'b1;
    for (int n = 0; n < 800; n++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        dg_a[i] = 7'($urandom);
        dg_b[i] = 7'($urandom);
      end
      dt_a = 4'($urandom);
      dt_b = 4'($urandom);
      if ($urandom_range(0, 24) == 0) en_a = ~en_a;
      if ($urandom_range(0, 49) == 0) en_b = ~en_b;
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sev_seg_displays_scanner.md
Name: sev_seg_displays_scanner

Overview:
Time-multiplexing driver for the 4-digit seven-segment display. It sits directly downstream of the seven-segment display bus interface and consumes its en, per-digit segment patterns and dot bits. It scans one digit at a time onto the shared physical segment and digit-select pins, inserting a blanking interval at the start of each slot to suppress ghosting. All pin outputs are registered.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot; must be >= 2.
BLANK_CYCLES, 500, cycles at the start of each slot with all selects inactive; must be < REFRESH_DIV; 0 allowed.
SEG_ACTIVE_LOW, 1, 1 means segments_out and dot_out drive 0 to light.
SEL_ACTIVE_LOW, 1, 1 means digit_sel drives 0 to enable a digit.

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
en  input  1  display enable from the bus interface control register
digit_0..digit_3  input  7 each  segment patterns, bit0=a ... bit6=g, 1=lit
dots  input  4  dot bits, dots[i] belongs to digit i, 1=lit
segments_out  output  7  physical segment pins, polarity per SEG_ACTIVE_LOW
dot_out  output  1  physical decimal-point pin, polarity per SEG_ACTIVE_LOW
digit_sel  output  4  physical digit enables, digit_sel[i] selects digit i, polarity per SEL_ACTIVE_LOW
scan_tick  output  1  one-cycle pulse at the end of each full frame

Behaviour:
- Internal state: idx (2 bits, slot digit), cnt (width clog2(REFRESH_DIV), 0..REFRESH_DIV-1), running flag, latched pattern (7 segment bits + 1 dot bit).
- All outputs are flops. No combinational path from any input to any output.
- Output values in a given cycle are a function of the state registers in that same cycle.
- Inactive level: segments and dot all unlit, all selects off (SEG/SEL_ACTIVE_LOW=1 gives segments_out=7'h7F, dot_out=1, digit_sel=4'hF). scan_tick=0.
- Reset (async): running=0, idx=0, cnt=0, pattern=0, all outputs at the inactive level immediately, without waiting for a clock edge.
- Idle (running=0):
  - Outputs stay inactive.
  - On a clock edge with en=1, the block goes to running=1, idx=0, cnt=0, and latches digit_0/dots[0].
  - The first cycle after that edge is slot 0, cnt 0.
- Running, each clock edge:
  - If cnt < REFRESH_DIV-1, cnt increments.
  - Otherwise cnt=0, idx=idx+1 (wraps 3->0), and digit_{idx+1}/dots[idx+1] are latched at that same edge.
- Pattern is sampled only at the edge entering cnt=0. Input changes mid-slot are not displayed until that digit's next slot.
- Running outputs:
  - While cnt < BLANK_CYCLES: selects all off, segments/dot unlit.
  - Otherwise: digit_sel has only bit idx active, and segments_out/dot_out show the latched pattern.
- scan_tick=1 exactly in the cycle where idx=3 and cnt=REFRESH_DIV-1, including when BLANK_CYCLES=0.
- Frame period = 4*REFRESH_DIV cycles.
- en deasserted while running: at the next edge running=0, idx=0, cnt=0, outputs inactive. A scan_tick due in that cycle is suppressed.
- en reasserted: scan restarts at slot 0 with a blanking interval; there is no resume mid-frame.
- Outputs never change except at clock edges or async reset. At most one select bit is active at any time.

Test Plan:
All scenarios use REFRESH_DIV=8, BLANK_CYCLES=2, active-low polarity unless stated.
1. Reset assert mid-scan, no clock edge -> segments_out=7'h7F, dot_out=1, digit_sel=4'hF, scan_tick=0 immediately; state returns to idle.
2. en=1 with digit_0..3=7'h3F,7'h06,7'h5B,7'h4F, dots=4'b0101:
   - Slot 0: cycles 0-1 digit_sel=F; cycles 2-7 digit_sel=4'b1110, segments_out=7'h40, dot_out=0.
   - Slot 1: digit_sel=4'b1101, segments_out=7'h79, dot_out=1.
   - Slot 2: 4'b1011, 7'h24, 0.
   - Slot 3: 4'b0111, 7'h30, 1.
   - scan_tick high once every 32 cycles, in the last cycle of slot 3.
3. Change digit_0 from 7'h3F to 7'h7F at slot 0 cnt=4 -> segments_out stays 7'h40 through that slot; shows 7'h00 in the next frame's slot 0.
4. Drop en at slot 2 cnt=5 -> outputs inactive from the next cycle, no scan_tick. Reassert after 3 cycles -> 2 blank cycles, then digit_sel=4'b1110.
5. BLANK_CYCLES=0, SEG_ACTIVE_LOW=0, SEL_ACTIVE_LOW=0, digit_0=7'h3F -> digit_sel=4'b0001 and segments_out=7'h3F from slot-0 cnt 0; never more than one select bit active over 3 frames.
